// File: rtl/kpn_display_pkg.sv
`default_nettype none
// ============================================================================
// Module : kpn_display_pkg
// Brief  : Shared ids, entry codes and scan FSM encoding for the KPN display.
// Rev    : 1.0  initial release
// ============================================================================
package kpn_display_pkg;

    localparam int         MOD_ID_W       = 5;
    localparam logic [4:0] MOD_ADDER      = 5'd0;
    localparam logic [4:0] MOD_SUBTRACTOR = 5'd1;
    localparam logic [4:0] MOD_BLANK      = 5'd31;

    localparam logic ENTRY_1 = 1'b0;
    localparam logic ENTRY_2 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHOW    = 2'd1,
        ST_ADVANCE = 2'd2
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/display_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module : display_scan_controller_if
// Brief  : Board-side controls and display-writer selects of the scan controller.
// Rev    : 1.0  initial release
// ============================================================================
interface display_scan_controller_if #(
    parameter int NUM_MODULES = 2,
    parameter int CNT_W       = 26
);
    import kpn_display_pkg::*;

    logic                   auto_enable;
    logic                   step_request;
    logic [NUM_MODULES-1:0] module_enable;
    logic                   select_entry;
    logic [MOD_ID_W-1:0]    select_module;
    logic                   update_strobe;
    logic [CNT_W-1:0]       dwell_count;

    // master: the scan controller; slave: the board / display-writer side
    modport master (
        input  auto_enable, step_request, module_enable,
        output select_entry, select_module, update_strobe, dwell_count
    );

    modport slave (
        output auto_enable, step_request, module_enable,
        input  select_entry, select_module, update_strobe, dwell_count
    );

endinterface
`default_nettype wire

// File: rtl/rr_next_select.sv
`default_nettype none
// ============================================================================
// Module : rr_next_select
// Brief  : Next enabled id strictly above cur_id, wrapping; cur_id itself last.
// Rev    : 1.0  initial release
// ============================================================================
module rr_next_select #(
    parameter int NUM_MODULES = 2
) (
    input  logic [4:0]             cur_id,
    input  logic [NUM_MODULES-1:0] enable_mask,
    output logic [4:0]             next_id,
    output logic                   none_enabled
);
    import kpn_display_pkg::*;

    int cand;

    // Walk offsets from farthest to nearest so the nearest enabled id wins.
    always_comb begin
        next_id      = MOD_BLANK;
        none_enabled = 1'b1;
        cand         = 0;
        for (int k = NUM_MODULES; k >= 1; k--) begin
            cand = (int'(cur_id) + k) % NUM_MODULES;
            for (int j = 0; j < NUM_MODULES; j++) begin
                if ((j == cand) && enable_mask[j]) begin
                    next_id      = 5'(j);
                    none_enabled = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : display_scan_controller
// Brief  : Round-robin (module, entry) scan driving the 7-segment display writer.
// Rev    : 1.0  initial release
// ============================================================================
module display_scan_controller #(
    parameter int NUM_MODULES  = 2,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                        clock,
    input  logic                        reset,
    display_scan_controller_if.master   bus
);
    import kpn_display_pkg::*;

    scan_state_e      state_q,     state_d;
    logic             step_prev_q, step_prev_d;
    logic             entry_q,     entry_d;
    logic [4:0]       module_q,    module_d;
    logic             strobe_q,    strobe_d;
    logic             changed_q,   changed_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic       step_edge;
    logic       expiry;
    logic       cur_enabled;
    logic [4:0] rr_cur;
    logic [4:0] rr_next;
    logic       rr_none;

    assign step_edge = bus.step_request & ~step_prev_q;
    assign expiry    = bus.auto_enable && (count_q == CNT_W'(DWELL_CYCLES - 1));

    // Outside ADVANCE, searching from the top id yields the lowest enabled id.
    assign rr_cur = (state_q == ST_ADVANCE) ? module_q : 5'(NUM_MODULES - 1);

    rr_next_select #(
        .NUM_MODULES (NUM_MODULES)
    ) u_rr_next_select (
        .cur_id       (rr_cur),
        .enable_mask  (bus.module_enable),
        .next_id      (rr_next),
        .none_enabled (rr_none)
    );

    always_comb begin
        cur_enabled = 1'b0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            if (module_q == 5'(i)) begin
                cur_enabled = bus.module_enable[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        module_d    = module_q;
        count_d     = count_q;
        changed_d   = 1'b0;
        strobe_d    = changed_q;
        step_prev_d = bus.step_request;

        case (state_q)
            ST_IDLE: begin
                if (!rr_none) begin
                    module_d  = rr_next;
                    entry_d   = ENTRY_1;
                    count_d   = '0;
                    changed_d = 1'b1;
                    state_d   = ST_SHOW;
                end
            end

            ST_SHOW: begin
                if (rr_none) begin
                    module_d  = MOD_BLANK;
                    entry_d   = ENTRY_1;
                    count_d   = '0;
                    changed_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!cur_enabled || step_edge || expiry) begin
                    count_d = '0;
                    state_d = ST_ADVANCE;
                end else if (bus.auto_enable) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            ST_ADVANCE: begin
                count_d   = '0;
                changed_d = 1'b1;
                state_d   = ST_SHOW;
                if (rr_none) begin
                    module_d = MOD_BLANK;
                    entry_d  = ENTRY_1;
                    state_d  = ST_IDLE;
                end else if ((entry_q == ENTRY_1) && cur_enabled) begin
                    entry_d = ENTRY_2;
                end else begin
                    // A module that lost its enable restarts the next one at entry 1.
                    module_d = rr_next;
                    entry_d  = ENTRY_1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_prev_q <= 1'b0;
            entry_q     <= ENTRY_1;
            module_q    <= MOD_BLANK;
            strobe_q    <= 1'b0;
            changed_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_prev_q <= step_prev_d;
            entry_q     <= entry_d;
            module_q    <= module_d;
            strobe_q    <= strobe_d;
            changed_q   <= changed_d;
            count_q     <= count_d;
        end
    end

    assign bus.select_entry  = entry_q;
    assign bus.select_module = module_q;
    assign bus.update_strobe = strobe_q;
    assign bus.dwell_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_display_scan_controller
// Brief  : Scoreboard bench for the display scan controller (DWELL=4, 2 modules).
// Rev    : 1.0  initial release
// ============================================================================
module tb_display_scan_controller;
    import kpn_display_pkg::*;

    localparam int NUM_MODULES  = 2;
    localparam int DWELL_CYCLES = 4;
    localparam int CNT_W        = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    display_scan_controller_if #(.NUM_MODULES(NUM_MODULES), .CNT_W(CNT_W)) bus ();

    display_scan_controller #(
        .NUM_MODULES  (NUM_MODULES),
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] mod;
        logic       ent;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input longint act, input longint want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input logic [4:0] mod, input logic ent, input int at);
        exp_q.push_back('{mod: mod, ent: ent, cyc: at});
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every strobe must match the oldest expected display event.
    int         chg_cyc   = -10;
    logic [4:0] prev_mod  = MOD_BLANK;
    logic       prev_ent  = ENTRY_1;
    bit         no_zero   = 1'b0;
    int         zero_viol = 0;

    always @(negedge clk) begin
        if (bus.select_module != prev_mod || bus.select_entry != prev_ent) chg_cyc = cyc;
        prev_mod = bus.select_module;
        prev_ent = bus.select_entry;
        if (no_zero && bus.select_module == 5'd0) zero_viol++;
        if (bus.update_strobe) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d showing (%0d,%0d), want none",
                         cyc, bus.select_module, bus.select_entry);
            end else begin
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_module", bus.select_module, e.mod);
                check("strobe_entry", bus.select_entry, e.ent);
                check("strobe_after_change", chg_cyc, cyc - 1);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_strobe: got none by cycle %0d, want (%0d,%0d) at cycle %0d",
                     cyc, exp_q[0].mod, exp_q[0].ent, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    int b;

    initial begin
        bus.auto_enable   = 1'b1;
        bus.step_request  = 1'b0;
        bus.module_enable = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_entry",  bus.select_entry,  0);
        check("rst_module", bus.select_module, 31);
        check("rst_strobe", bus.update_strobe, 0);
        check("rst_count",  bus.dwell_count,   0);

        // Auto scan over both modules, wrapping back to (0,E1)
        b = cyc;
        rst = 1'b0;
        push(5'd0, 1'b0, b + 2);
        push(5'd0, 1'b1, b + 7);
        push(5'd1, 1'b0, b + 12);
        push(5'd1, 1'b1, b + 17);
        push(5'd0, 1'b0, b + 22);
        wait_cyc(b + 22);
        bus.auto_enable = 1'b0;
        wait_cyc(b + 24);
        check("count_held", bus.dwell_count, 1);

        // Manual stepping; second pulse held for 10 cycles
        b = cyc;
        bus.step_request = 1'b1;
        push(5'd0, 1'b1, b + 3);
        wait_cyc(b + 1);
        bus.step_request = 1'b0;
        wait_cyc(b + 6);
        b = cyc;
        bus.step_request = 1'b1;
        push(5'd1, 1'b0, b + 3);
        wait_cyc(b + 10);
        bus.step_request = 1'b0;
        wait_cyc(b + 14);
        check("count_manual", bus.dwell_count, 0);
        b = cyc;
        bus.step_request = 1'b1;
        push(5'd1, 1'b1, b + 3);
        wait_cyc(b + 1);
        bus.step_request = 1'b0;
        wait_cyc(b + 6);

        // Current module disabled, then everything disabled
        b = cyc;
        bus.module_enable = 2'b01;
        push(5'd0, 1'b0, b + 3);
        wait_cyc(b + 6);
        b = cyc;
        bus.module_enable = 2'b00;
        push(5'd31, 1'b0, b + 2);
        wait_cyc(b + 6);
        check("blank_state",  dut.state_q, ST_IDLE);
        check("blank_module", bus.select_module, 31);

        // Step edge coinciding with dwell expiry
        b = cyc;
        bus.module_enable = 2'b11;
        bus.auto_enable   = 1'b1;
        push(5'd0, 1'b0, b + 2);
        wait_cyc(b + 4);
        check("count_expiry", bus.dwell_count, 3);
        bus.step_request = 1'b1;
        push(5'd0, 1'b1, b + 7);
        push(5'd1, 1'b0, b + 12);
        wait_cyc(b + 5);
        bus.step_request = 1'b0;
        wait_cyc(b + 6);
        check("count_restart", bus.dwell_count, 0);

        // Reset pulse during ADVANCE
        wait_cyc(b + 15);
        check("in_advance", dut.state_q, ST_ADVANCE);
        #1;
        rst = 1'b1;
        bus.module_enable = 2'b10;
        #1;
        check("async_entry",  bus.select_entry,  0);
        check("async_module", bus.select_module, 31);
        check("async_strobe", bus.update_strobe, 0);
        check("async_count",  bus.dwell_count,   0);
        check("async_state",  dut.state_q, ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single enabled module toggles its entries
        b = cyc;
        no_zero = 1'b1;
        push(5'd1, 1'b0, b + 2);
        push(5'd1, 1'b1, b + 7);
        push(5'd1, 1'b0, b + 12);
        push(5'd1, 1'b1, b + 17);
        wait_cyc(b + 20);
        check("never_module0", zero_viol, 0);

        for (int g = 0; g < 50 && exp_q.size() > 0; g++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d strobes outstanding, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
